// File: rtl/udt_pkg.sv
// Shared definitions for the UDT transmit path: grant codes, scheduler FSM states
// and modular sequence-number arithmetic.
package udt_pkg;

    localparam int SEQ_W_DEFAULT = 31;

    localparam logic [1:0] GNT_NONE   = 2'd0;
    localparam logic [1:0] GNT_CTRL   = 2'd1;
    localparam logic [1:0] GNT_REXMIT = 2'd2;
    localparam logic [1:0] GNT_DATA   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CTRL   = 2'd1,
        ST_REXMIT = 2'd2,
        ST_DATA   = 2'd3
    } udt_state_e;

    // Distance from b forward to a on the sequence circle.
    function automatic logic [SEQ_W_DEFAULT-1:0] seq_diff(
        input logic [SEQ_W_DEFAULT-1:0] a,
        input logic [SEQ_W_DEFAULT-1:0] b
    );
        return a - b;
    endfunction

endpackage

// File: rtl/udt_pace_timer.sv
// Inter-packet pacing timer: loaded at the start of a paced packet, counts down
// to zero and saturates; zero means the next paced packet may be granted.
module udt_pace_timer #(
    parameter int PERIOD_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [PERIOD_W-1:0] period,
    output logic                zero
);

    logic [PERIOD_W-1:0] cnt_r;
    logic [PERIOD_W-1:0] load_val_s;

    // The first beat and the arbitration cycle are part of the period, so they
    // are taken off the load value; this keeps packet starts exactly period apart.
    always_comb begin
        if (period > PERIOD_W'(2)) begin
            load_val_s = period - PERIOD_W'(2);
        end else begin
            load_val_s = {PERIOD_W{1'b0}};
        end
    end

    // Countdown register, saturating at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {PERIOD_W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val_s;
        end else if (cnt_r != {PERIOD_W{1'b0}}) begin
            cnt_r <= cnt_r - PERIOD_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {PERIOD_W{1'b0}});

endmodule

// File: rtl/udt_tx_scheduler.sv
// UDT transmit scheduler: ctrl > rexmit > data packet arbitration with pacing,
// flow window and data sequence numbering. Optional counters: UDT_TX_SCHED_STATS_EN.
module udt_tx_scheduler
    import udt_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int KEEP_W   = 8,
    parameter int SEQ_W    = SEQ_W_DEFAULT,
    parameter int PERIOD_W = 32,
    parameter int WIN_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_enable,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [WIN_W-1:0]    cfg_flow_win,
    input  logic                ack_valid,
    input  logic [SEQ_W-1:0]    ack_seq,
    input  logic                ctrl_s_axis_tvalid,
    output logic                ctrl_s_axis_tready,
    input  logic [DATA_W-1:0]   ctrl_s_axis_tdata,
    input  logic [KEEP_W-1:0]   ctrl_s_axis_tkeep,
    input  logic                ctrl_s_axis_tlast,
    input  logic                rexmit_s_axis_tvalid,
    output logic                rexmit_s_axis_tready,
    input  logic [DATA_W-1:0]   rexmit_s_axis_tdata,
    input  logic [KEEP_W-1:0]   rexmit_s_axis_tkeep,
    input  logic                rexmit_s_axis_tlast,
    input  logic                data_s_axis_tvalid,
    output logic                data_s_axis_tready,
    input  logic [DATA_W-1:0]   data_s_axis_tdata,
    input  logic [KEEP_W-1:0]   data_s_axis_tkeep,
    input  logic                data_s_axis_tlast,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic [KEEP_W-1:0]   m_axis_tkeep,
    output logic                m_axis_tlast,
    output logic [SEQ_W-1:0]    tx_seq,
    output logic                tx_seq_valid,
    output logic [1:0]          grant
`ifdef UDT_TX_SCHED_STATS_EN
    ,
    output logic [31:0]         stat_ctrl_pkts,
    output logic [31:0]         stat_rexmit_pkts,
    output logic [31:0]         stat_data_pkts,
    output logic [31:0]         stat_win_stall_cycles
`endif
);

    localparam int CMP_W = (SEQ_W > WIN_W) ? SEQ_W : WIN_W;

    udt_state_e       state_r;
    logic [1:0]       grant_r;
    logic             seq_valid_r;
    logic             first_r;
    logic [SEQ_W-1:0] next_seq_r;
    logic [SEQ_W-1:0] ack_seq_r;
    logic [SEQ_W-1:0] inflight_s;
    logic             win_ok_s;
    logic             pace_zero_s;
    logic             pace_load_s;
    logic             beat_s;
    logic             last_beat_s;

    assign beat_s      = m_axis_tvalid && m_axis_tready;
    assign last_beat_s = beat_s && m_axis_tlast;
    assign inflight_s  = seq_diff(next_seq_r, ack_seq_r);
    assign win_ok_s    = (CMP_W'(inflight_s) < CMP_W'(cfg_flow_win));
    assign pace_load_s = beat_s && first_r &&
                         ((state_r == ST_REXMIT) || (state_r == ST_DATA));

    udt_pace_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_pace (
        .clk    (clk),
        .rst    (rst),
        .load   (pace_load_s),
        .period (cfg_period),
        .zero   (pace_zero_s)
    );

    // Arbitration FSM; grant and tx_seq_valid are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            grant_r     <= GNT_NONE;
            seq_valid_r <= 1'b0;
            first_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cfg_enable && ctrl_s_axis_tvalid) begin
                        state_r     <= ST_CTRL;
                        grant_r     <= GNT_CTRL;
                        seq_valid_r <= 1'b0;
                        first_r     <= 1'b1;
                    end else if (cfg_enable && rexmit_s_axis_tvalid && pace_zero_s) begin
                        state_r     <= ST_REXMIT;
                        grant_r     <= GNT_REXMIT;
                        seq_valid_r <= 1'b0;
                        first_r     <= 1'b1;
                    end else if (cfg_enable && data_s_axis_tvalid && pace_zero_s && win_ok_s) begin
                        state_r     <= ST_DATA;
                        grant_r     <= GNT_DATA;
                        seq_valid_r <= 1'b1;
                        first_r     <= 1'b1;
                    end else begin
                        state_r     <= ST_IDLE;
                        grant_r     <= GNT_NONE;
                        seq_valid_r <= 1'b0;
                        first_r     <= 1'b0;
                    end
                end
                ST_CTRL, ST_REXMIT, ST_DATA: begin
                    if (last_beat_s) begin
                        state_r     <= ST_IDLE;
                        grant_r     <= GNT_NONE;
                        seq_valid_r <= 1'b0;
                        first_r     <= 1'b0;
                    end else if (beat_s) begin
                        first_r     <= 1'b0;
                    end else begin
                        first_r     <= first_r;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    grant_r     <= GNT_NONE;
                    seq_valid_r <= 1'b0;
                    first_r     <= 1'b0;
                end
            endcase
        end
    end

    // Sequence allocation and peer acknowledgement tracking; both may update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            next_seq_r <= {SEQ_W{1'b0}};
            ack_seq_r  <= {SEQ_W{1'b0}};
        end else begin
            if (last_beat_s && (state_r == ST_DATA)) begin
                next_seq_r <= next_seq_r + SEQ_W'(1);
            end else begin
                next_seq_r <= next_seq_r;
            end
            if (ack_valid) begin
                ack_seq_r <= ack_seq;
            end else begin
                ack_seq_r <= ack_seq_r;
            end
        end
    end

    // Combinational output path from the locked source; no buffering.
    always_comb begin
        m_axis_tvalid        = 1'b0;
        m_axis_tdata         = {DATA_W{1'b0}};
        m_axis_tkeep         = {KEEP_W{1'b0}};
        m_axis_tlast         = 1'b0;
        ctrl_s_axis_tready   = 1'b0;
        rexmit_s_axis_tready = 1'b0;
        data_s_axis_tready   = 1'b0;
        case (state_r)
            ST_CTRL: begin
                m_axis_tvalid      = ctrl_s_axis_tvalid;
                m_axis_tdata       = ctrl_s_axis_tdata;
                m_axis_tkeep       = ctrl_s_axis_tkeep;
                m_axis_tlast       = ctrl_s_axis_tlast;
                ctrl_s_axis_tready = m_axis_tready;
            end
            ST_REXMIT: begin
                m_axis_tvalid        = rexmit_s_axis_tvalid;
                m_axis_tdata         = rexmit_s_axis_tdata;
                m_axis_tkeep         = rexmit_s_axis_tkeep;
                m_axis_tlast         = rexmit_s_axis_tlast;
                rexmit_s_axis_tready = m_axis_tready;
            end
            ST_DATA: begin
                m_axis_tvalid      = data_s_axis_tvalid;
                m_axis_tdata       = data_s_axis_tdata;
                m_axis_tkeep       = data_s_axis_tkeep;
                m_axis_tlast       = data_s_axis_tlast;
                data_s_axis_tready = m_axis_tready;
            end
            default: begin
                m_axis_tvalid = 1'b0;
            end
        endcase
    end

    assign tx_seq       = next_seq_r;
    assign tx_seq_valid = seq_valid_r;
    assign grant        = grant_r;

`ifdef UDT_TX_SCHED_STATS_EN
    logic [31:0] stat_ctrl_r;
    logic [31:0] stat_rexmit_r;
    logic [31:0] stat_data_r;
    logic [31:0] stat_stall_r;

    // Wrapping packet and window-stall counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ctrl_r   <= 32'd0;
            stat_rexmit_r <= 32'd0;
            stat_data_r   <= 32'd0;
            stat_stall_r  <= 32'd0;
        end else begin
            if (last_beat_s && (state_r == ST_CTRL)) begin
                stat_ctrl_r <= stat_ctrl_r + 32'd1;
            end else begin
                stat_ctrl_r <= stat_ctrl_r;
            end
            if (last_beat_s && (state_r == ST_REXMIT)) begin
                stat_rexmit_r <= stat_rexmit_r + 32'd1;
            end else begin
                stat_rexmit_r <= stat_rexmit_r;
            end
            if (last_beat_s && (state_r == ST_DATA)) begin
                stat_data_r <= stat_data_r + 32'd1;
            end else begin
                stat_data_r <= stat_data_r;
            end
            if ((state_r == ST_IDLE) && data_s_axis_tvalid && pace_zero_s && !win_ok_s) begin
                stat_stall_r <= stat_stall_r + 32'd1;
            end else begin
                stat_stall_r <= stat_stall_r;
            end
        end
    end

    assign stat_ctrl_pkts        = stat_ctrl_r;
    assign stat_rexmit_pkts      = stat_rexmit_r;
    assign stat_data_pkts        = stat_data_r;
    assign stat_win_stall_cycles = stat_stall_r;
`endif

endmodule
